a23_out_unloader: RTL and testbench
===================================

Name: a23_out_unloader

Overview:
Sits directly downstream of a23_gc_main. It counts core clock cycles from run start until the core asserts terminate, then snapshots the flattened output memory o. It streams the snapshot out as OUT_MEM_SIZE 32-bit words over a valid/ready interface, so results can leave the block without a wide parallel tap and the core can be reset during streaming.

Parameters:
OUT_MEM_SIZE, 64, number of 32-bit output words in o (same value as the core's OUT_MEM_SIZE); must be >= 2
CC_WIDTH, 32, width of the cycle counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse: core has left reset, begin counting
terminate  input  1  core terminate flag
o  input  OUT_MEM_SIZE*32  core output memory, word i at bits [32*(i+1)-1:32*i]
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word
m_data  output  32  current output word
m_index  output  $clog2(OUT_MEM_SIZE)  index of current word
m_last  output  1  current word is index OUT_MEM_SIZE-1
cycle_count  output  CC_WIDTH  cycles spent in RUN with terminate low
busy  output  1  state is RUN or STREAM
done  output  1  all words accepted; held until next start

Behaviour:
- Reset (rst_n=0, async): state IDLE; m_valid=0, m_data=0, m_index=0, m_last=0, cycle_count=0, busy=0, done=0; snapshot cleared to 0.
- States: IDLE, RUN, STREAM, DONE.
- IDLE: start=1 -> RUN, cycle_count<=0. Other inputs ignored.
- RUN: each cycle with terminate=0 increments cycle_count. The counter saturates at all-ones and does not wrap.
- RUN with terminate=1: snapshot<=o that same edge; cycle_count is not incremented; -> STREAM with m_index=0. m_valid=1 from the next cycle.
- terminate already high in the first RUN cycle gives cycle_count=0.
- start while in RUN or STREAM is ignored.
- STREAM handshake:
  - m_data = snapshot word m_index, driven from registers. It never depends on the live o after capture.
  - A transfer occurs on an edge with m_valid and m_ready both high.
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable.
  - After a transfer at index k < OUT_MEM_SIZE-1, m_index=k+1 next cycle. The stream sustains one word per cycle with m_ready held high.
  - m_last=1 exactly when m_index=OUT_MEM_SIZE-1.
  - The transfer with m_last=1 -> DONE, with m_valid=0 next cycle.
- DONE: done=1, cycle_count holds its final value. start=1 -> RUN with cycle_count<=0 and done<=0 that edge.
- busy=1 in RUN and STREAM, 0 otherwise.
- Reset mid-RUN or mid-STREAM: immediate return to IDLE with all outputs at reset values. A partial stream is discarded and never resumed.
- Latency:
  - terminate edge to first m_valid: 1 cycle.
  - Full drain with m_ready=1: OUT_MEM_SIZE cycles.
  - Last transfer to done=1: 1 cycle.

Decomposition:
- Shared package a23_gc_pkg:
  - word width constant 32.
  - state enum (IDLE/RUN/STREAM/DONE).
  - address-map constants (code 0x00000000, alice 0x01000000, bob 0x02000000, out 0x03000000, stack 0x04000100) for benches.
- One natural sub-module, a23_word_mux: registered selection of word m_index from the snapshot vector.
- Counter and FSM stay in the top.

Test Plan:
1. Reset, start pulse, terminate held low 100 cycles then raised, o word i = 32'hA5A50000+i, m_ready=1 -> cycle_count=100; 64 words 0xA5A50000..0xA5A5003F in order; m_last only on index 63; done one cycle after.
2. Same run with m_ready toggling 1,0,0,1 pattern -> m_data/m_index stable during every stall; all 64 words delivered exactly once; no duplicates or skips.
3. Change o to all 32'hDEADBEEF one cycle after terminate capture -> streamed data still matches the captured values from scenario 1.
4. start then terminate high in the first RUN cycle -> cycle_count=0; first m_valid one cycle later with m_data=word 0.
5. CC_WIDTH=4, terminate low 20 cycles -> cycle_count saturates at 15; stream completes normally.
6. rst_n low asynchronously mid-stream at index 10 -> outputs reset immediately without a clock edge. Next start plus terminate gives a fresh stream from index 0; done pulses only after index 63.

Source files
------------

// File: rtl/a23_gc_pkg.sv
// Shared definitions for the a23 garbled-circuit core wrapper blocks:
// word width, unloader state encoding and the core's memory map.
`timescale 1ns/1ps
package a23_gc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Memory map of the core, used by benches to place code and data.
    localparam logic [31:0] ADDR_CODE  = 32'h0000_0000;
    localparam logic [31:0] ADDR_ALICE = 32'h0100_0000;
    localparam logic [31:0] ADDR_BOB   = 32'h0200_0000;
    localparam logic [31:0] ADDR_OUT   = 32'h0300_0000;
    localparam logic [31:0] ADDR_STACK = 32'h0400_0100;

endpackage

// File: rtl/a23_word_mux.sv
// Registered word selector: loads word[sel] of a flattened vector when en is
// high, so the stream data comes straight from a flop.
`timescale 1ns/1ps
module a23_word_mux
    import a23_gc_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [WORDS*WORD_W-1:0]   vec,
    input  logic [IW-1:0]             sel,
    output logic [WORD_W-1:0]         word
);

    logic [WORD_W-1:0] words [WORDS];

    for (genvar i = 0; i < WORDS; i++) begin : g_split
        assign words[i] = vec[i*WORD_W +: WORD_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (en) begin
            word <= words[sel];
        end
    end

endmodule

// File: rtl/a23_out_unloader.sv
// Counts core cycles until terminate, snapshots the core output memory and
// streams it out one 32-bit word at a time over valid/ready.
`timescale 1ns/1ps
module a23_out_unloader
    import a23_gc_pkg::*;
#(
    parameter int OUT_MEM_SIZE = 64,
    parameter int CC_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              terminate,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0]    o,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [WORD_W-1:0]                 m_data,
    output logic [$clog2(OUT_MEM_SIZE)-1:0]   m_index,
    output logic                              m_last,
    output logic [CC_WIDTH-1:0]               cycle_count,
    output logic                              busy,
    output logic                              done
);

    localparam int            IW       = $clog2(OUT_MEM_SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(OUT_MEM_SIZE - 1);

    state_t                           state;
    logic [OUT_MEM_SIZE*WORD_W-1:0]   snapshot;
    logic [OUT_MEM_SIZE*WORD_W-1:0]   src_vec;
    logic                             capture;
    logic                             xfer;
    logic [IW-1:0]                    next_index;

    assign capture = (state == RUN) && terminate;
    assign xfer    = (state == STREAM) && m_valid && m_ready;

    // At capture the mux must read the live o, since snapshot loads on the same edge.
    assign src_vec    = capture ? o : snapshot;
    assign next_index = capture             ? '0 :
                        (xfer && !m_last)   ? m_index + IW'(1) :
                                              m_index;

    a23_word_mux #(
        .WORDS (OUT_MEM_SIZE),
        .IW    (IW)
    ) u_word_mux (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (capture || xfer),
        .vec   (src_vec),
        .sel   (next_index),
        .word  (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            snapshot    <= '0;
            m_valid     <= 1'b0;
            m_index     <= '0;
            m_last      <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (terminate) begin
                        state    <= STREAM;
                        snapshot <= o;
                        m_valid  <= 1'b1;
                        m_index  <= '0;
                        m_last   <= (LAST_IDX == '0);
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CC_WIDTH'(1);
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (m_last) begin
                            state   <= DONE;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            m_index <= next_index;
                            m_last  <= (next_index == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a23_out_unloader.sv
// Randomized bench for a23_out_unloader; a second instance with a 4-bit
// counter shares all inputs to exercise counter saturation.
`timescale 1ns/1ps
module tb_a23_out_unloader;
    import a23_gc_pkg::*;

    localparam int N  = 64;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              terminate;
    logic [N*32-1:0]   o;
    logic              m_ready;

    logic              m_valid, m_last, busy, done;
    logic [31:0]       m_data;
    logic [IW-1:0]     m_index;
    logic [31:0]       cycle_count;

    logic              s_valid, s_last, s_busy, s_done;
    logic [31:0]       s_data;
    logic [IW-1:0]     s_index;
    logic [3:0]        s_count;

    int total = 0;
    int bad   = 0;

    a23_out_unloader #(.OUT_MEM_SIZE(N), .CC_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .terminate(terminate), .o(o),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .cycle_count(cycle_count), .busy(busy), .done(done)
    );

    a23_out_unloader #(.OUT_MEM_SIZE(N), .CC_WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .terminate(terminate), .o(o),
        .m_valid(s_valid), .m_ready(m_ready), .m_data(s_data), .m_index(s_index),
        .m_last(s_last), .cycle_count(s_count), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(m_valid), 64'(0));
        check_val({tag, "_data"},  64'(m_data), 64'(0));
        check_val({tag, "_index"}, 64'(m_index), 64'(0));
        check_val({tag, "_last"},  64'(m_last), 64'(0));
        check_val({tag, "_count"}, 64'(cycle_count), 64'(0));
        check_val({tag, "_busy"},  64'(busy), 64'(0));
        check_val({tag, "_done"},  64'(done), 64'(0));
        check_val({tag, "_sdone"}, 64'(s_done), 64'(0));
    endtask

    // One complete job: start, n idle-run cycles, terminate, drain.
    // wmode: 0 = A5A5 pattern, 1 = random words. rmode: 0 = ready high,
    // 1 = 1,0,0,1 pattern, 2 = random ready plus stray start pulses.
    task automatic run_job(input int n, input int wmode, input int rmode,
                           input bit corrupt, input int abort_idx);
        logic [31:0] exp_w [N];
        int          accepted;
        int          cyc;
        bit          aborted;
        bit          rdy;
        int          exp_small;

        exp_small = (n > 15) ? 15 : n;
        for (int i = 0; i < N; i++)
            o[32*i +: 32] = (wmode == 0) ? (32'hA5A5_0000 + 32'(i)) : $urandom;

        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        terminate = 1'b0;
        check_val("run_busy",  64'(busy), 64'(1));
        check_val("run_done",  64'(done), 64'(0));
        check_val("run_count0", 64'(cycle_count), 64'(0));

        repeat (n) @(negedge clk);
        terminate = 1'b1;
        for (int i = 0; i < N; i++) exp_w[i] = o[32*i +: 32];
        @(negedge clk);
        terminate = 1'b0;
        if (corrupt) o = {N{32'hDEAD_BEEF}};
        check_val("count",       64'(cycle_count), 64'(n));
        check_val("count_small", 64'(s_count), 64'(exp_small));

        accepted = 0;
        cyc      = 0;
        aborted  = 1'b0;
        while (accepted < N && cyc < 1000) begin
            check_val("valid", 64'(m_valid), 64'(1));
            check_val("index", 64'(m_index), 64'(accepted));
            check_val("data",  64'(m_data), 64'(exp_w[accepted]));
            check_val("last",  64'(m_last), 64'(accepted == N - 1));
            check_val("done_early", 64'(done), 64'(0));
            if (accepted == abort_idx) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                #1;
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            m_ready = rdy;
            start   = (rmode == 2) && ($urandom_range(0, 7) == 0);
            @(posedge clk);
            if (rdy) accepted++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        m_ready = 1'b0;

        if (!aborted) begin
            check_val("drained", 64'(accepted), 64'(N));
            if (rmode == 0) check_val("drain_cycles", 64'(cyc), 64'(N));
            check_val("end_done",   64'(done), 64'(1));
            check_val("end_valid",  64'(m_valid), 64'(0));
            check_val("end_busy",   64'(busy), 64'(0));
            check_val("end_count",  64'(cycle_count), 64'(n));
            check_val("end_sdone",  64'(s_done), 64'(1));
            check_val("end_scount", 64'(s_count), 64'(exp_small));
            @(negedge clk);
            check_val("done_held", 64'(done), 64'(1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        terminate = 1'b0;
        m_ready   = 1'b0;
        o         = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(100, 0, 0, 1'b0, -1);
        run_job(100, 0, 1, 1'b0, -1);
        run_job(100, 0, 0, 1'b1, -1);
        run_job(0,   1, 0, 1'b0, -1);
        run_job(20,  1, 2, 1'b0, -1);
        run_job(5,   0, 0, 1'b0, 10);
        check_val("abort_idle_done", 64'(done), 64'(0));
        run_job(7,   1, 0, 1'b0, -1);
        for (int k = 0; k < 4; k++)
            run_job(int'($urandom_range(0, 40)), 1, int'($urandom_range(0, 2)), 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
